// File: rtl/ccc_mon_pkg.sv
// Shared types and default limits for the CCC lock monitor.
// State and cause encodings are visible on the STATE and FAULT_CAUSE ports.
package ccc_mon_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_STAB  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'd0,
    CAUSE_LOCK_LOST   = 2'd1,
    CAUSE_FREQ        = 2'd2,
    CAUSE_REF_MISSING = 2'd3
  } cause_e;

  // 40 MHz fabric clock against a 32.768 kHz reference gives ~1221 cycles.
  localparam int DEF_EXP_MIN = 1190;
  localparam int DEF_EXP_MAX = 1250;
  localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/ccc_period_meter.sv
// Measures FAB_CLK cycles per reference period; the reference is sampled as data.
// Reports each measurement with a range verdict and flags a missing reference.
module ccc_period_meter
  import ccc_mon_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int EXP_MIN = DEF_EXP_MIN,
  parameter int EXP_MAX = DEF_EXP_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ref,
  output logic             o_meas_valid,
  output logic             o_in_range,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_last_period
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MAX_V   = CNT_W'(EXP_MAX);
  localparam logic [CNT_W-1:0] TO_V    = CNT_W'(2 * EXP_MAX);

  logic [2:0]       r_ref_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last_period;
  logic             r_meas_valid;
  logic             r_in_range;
  logic             w_ref_edge;
  logic [CNT_W-1:0] w_period;

  assign w_ref_edge = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_period   = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_sync    <= 3'b000;
      r_cnt         <= '0;
      r_last_period <= '0;
      r_meas_valid  <= 1'b0;
      r_in_range    <= 1'b0;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], i_ref};
      if (w_ref_edge) begin
        r_cnt         <= '0;
        r_last_period <= w_period;
        r_meas_valid  <= 1'b1;
        r_in_range    <= (w_period >= MIN_V) && (w_period <= MAX_V);
      end else begin
        r_meas_valid <= 1'b0;
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // An edge arriving on the timeout count restarts the meter instead.
  assign o_timeout     = (r_cnt == TO_V) && !w_ref_edge;
  assign o_meas_valid  = r_meas_valid;
  assign o_in_range    = r_in_range;
  assign o_last_period = r_last_period;

endmodule

// File: rtl/ccc_lock_monitor.sv
// Fabric reset sequencer for the MSS CCC: waits for stable lock and a verified
// FAB_CLK frequency before releasing FAB_RST, and records why it re-asserts.
module ccc_lock_monitor
  import ccc_mon_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int EXP_MIN            = DEF_EXP_MIN,
  parameter int EXP_MAX            = DEF_EXP_MAX,
  parameter int CNT_W              = DEF_CNT_W,
  parameter int RST_STRETCH        = 16,
  parameter int AUTO_RETRY         = 1,
  parameter int FCNT_W             = 8
) (
  input  logic              FAB_CLK,
  input  logic              RESET,
  input  logic              LOCK_IN,
  input  logic              REF_IN,
  input  logic              CLR_STATUS,
  input  logic              RETRY,
  output logic              FAB_RST,
  output logic              READY,
  output logic [1:0]        FAULT_CAUSE,
  output logic [FCNT_W-1:0] FAULT_CNT,
  output logic [CNT_W-1:0]  LAST_PERIOD,
  output logic [2:0]        STATE
);

  localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int STR_W  = $clog2(RST_STRETCH + 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = '1;

  logic [1:0]        r_lock_sync;
  state_e            r_state;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STR_W-1:0]  r_str_cnt;
  logic              r_aligned;
  logic              r_retry_pend;
  logic              r_fab_rst;
  logic              r_ready;
  cause_e            r_cause;
  logic [FCNT_W-1:0] r_fcnt;

  logic              w_lock_s;
  logic              w_meas_valid;
  logic              w_in_range;
  logic              w_timeout;
  logic              w_str_done;
  state_e            w_next;
  cause_e            w_new_cause;
  logic              w_fault_entry;

  assign w_lock_s   = r_lock_sync[1];
  assign w_str_done = (r_str_cnt == STR_W'(RST_STRETCH - 1));

  ccc_period_meter #(
    .CNT_W   (CNT_W),
    .EXP_MIN (EXP_MIN),
    .EXP_MAX (EXP_MAX)
  ) u_meter (
    .i_clk         (FAB_CLK),
    .i_rst         (RESET),
    .i_ref         (REF_IN),
    .o_meas_valid  (w_meas_valid),
    .o_in_range    (w_in_range),
    .o_timeout     (w_timeout),
    .o_last_period (LAST_PERIOD)
  );

  // Fault priority inside RUN and CHECK: lock loss, then missing ref, then frequency.
  always_comb begin
    w_next      = r_state;
    w_new_cause = CAUSE_NONE;
    case (r_state)
      ST_HOLD: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_lock_s) w_next = ST_STAB;
        else          w_next = ST_WAIT;
      end
      ST_STAB: begin
        if (!w_lock_s)                                          w_next = ST_WAIT;
        else if (r_stab_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1)) w_next = ST_CHECK;
        else                                                    w_next = ST_STAB;
      end
      ST_CHECK: begin
        if (!w_lock_s) begin
          w_next = ST_WAIT;
        end else if (w_timeout) begin
          w_next      = ST_FAULT;
          w_new_cause = CAUSE_REF_MISSING;
        end else if (w_meas_valid && r_aligned) begin
          if (w_in_range) begin
            w_next = ST_RUN;
          end else begin
            w_next      = ST_FAULT;
            w_new_cause = CAUSE_FREQ;
          end
        end else begin
          w_next = ST_CHECK;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_next      = ST_FAULT;
          w_new_cause = CAUSE_LOCK_LOST;
        end else if (w_timeout) begin
          w_next      = ST_FAULT;
          w_new_cause = CAUSE_REF_MISSING;
        end else if (w_meas_valid && !w_in_range) begin
          w_next      = ST_FAULT;
          w_new_cause = CAUSE_FREQ;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (w_str_done && ((AUTO_RETRY != 0) || r_retry_pend || RETRY)) w_next = ST_WAIT;
        else                                                           w_next = ST_FAULT;
      end
      default: w_next = ST_HOLD;
    endcase
    w_fault_entry = (w_next == ST_FAULT) && (r_state != ST_FAULT);
  end

  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      r_lock_sync  <= 2'b00;
      r_state      <= ST_HOLD;
      r_stab_cnt   <= '0;
      r_str_cnt    <= '0;
      r_aligned    <= 1'b0;
      r_retry_pend <= 1'b0;
      r_fab_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_cause      <= CAUSE_NONE;
      r_fcnt       <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], LOCK_IN};
      r_state     <= w_next;
      r_stab_cnt  <= (r_state == ST_STAB) ? r_stab_cnt + STAB_W'(1) : '0;
      if (r_state != ST_FAULT) begin
        r_str_cnt <= '0;
      end else if (!w_str_done) begin
        r_str_cnt <= r_str_cnt + STR_W'(1);
      end
      r_retry_pend <= (r_state == ST_FAULT) && (r_retry_pend || RETRY);
      // The first reference edge seen in CHECK only aligns the meter.
      r_aligned    <= (r_state == ST_CHECK) && (r_aligned || w_meas_valid);
      // Release lags RUN entry by a cycle; re-assertion coincides with leaving RUN.
      r_fab_rst    <= !((r_state == ST_RUN) && (w_next == ST_RUN));
      r_ready      <=  (r_state == ST_RUN) && (w_next == ST_RUN);
      if (w_fault_entry) begin
        r_cause <= w_new_cause;
        if (CLR_STATUS)              r_fcnt <= FCNT_W'(1);
        else if (r_fcnt != FCNT_MAX) r_fcnt <= r_fcnt + FCNT_W'(1);
      end else if (CLR_STATUS) begin
        r_cause <= CAUSE_NONE;
        r_fcnt  <= '0;
      end
    end
  end

  assign FAB_RST     = r_fab_rst;
  assign READY       = r_ready;
  assign FAULT_CAUSE = r_cause;
  assign FAULT_CNT   = r_fcnt;
  assign STATE       = r_state;

endmodule
